// File: rtl/alu_ex_stage_pkg.sv
// Shared CPU definitions for the execute stage: op codes, skid FSM encoding
// and the payload carried through the output registers.
package alu_ex_stage_pkg;

    localparam int unsigned OpWidth = 4;
    localparam int unsigned DataW   = 32;
    localparam int unsigned RegW    = 5;

    typedef enum logic [OpWidth-1:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpSlt  = 4'd2,
        OpSltu = 4'd3,
        OpAnd  = 4'd4,
        OpOr   = 4'd5,
        OpXor  = 4'd6,
        OpSll  = 4'd7,
        OpSrl  = 4'd8,
        OpSra  = 4'd9,
        OpPass = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [DataW-1:0] result;
        logic [RegW-1:0]  rd;
    } ex_payload_t;

endpackage

// File: rtl/alu_ex_stage_shifter.sv
// Barrel shifter: one left shift and one right shift with a selectable fill bit
// (zero for logical, sign for arithmetic).
module alu_ex_stage_shifter (
    input  logic [31:0] data_i,
    input  logic [4:0]  amount_i,
    input  logic        extn_i,
    output logic [31:0] left_o,
    output logic [31:0] right_o
);

    logic [63:0] ext_data;

    assign ext_data = {{32{extn_i}}, data_i};
    assign left_o   = data_i << amount_i;
    // Fill bits come from the upper half shifting down into the low word.
    assign right_o  = 32'(ext_data >> amount_i);

endmodule

// File: rtl/alu_ex_stage.sv
// Single-cycle ALU execute stage with a two-entry (main + skid) output buffer;
// in_ready is registered so downstream backpressure never reaches upstream combinationally.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned OP_W = OpWidth
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [31:0]     in_src0,
    input  logic [31:0]     in_src1,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [4:0]      out_rd
);

    skid_state_e state_q, state_d;
    ex_payload_t main_q, main_d;
    ex_payload_t skid_q, skid_d;
    logic        in_ready_q, in_ready_d;

    logic [31:0] shl_res;
    logic [31:0] shr_res;
    logic        shr_extn;
    logic [31:0] alu_res;
    ex_payload_t incoming;
    logic        accept;
    logic        transfer;

    assign shr_extn = (in_op == OpSra) ? in_src0[31] : 1'b0;

    alu_ex_stage_shifter u_shifter (
        .data_i   (in_src0),
        .amount_i (in_src1[4:0]),
        .extn_i   (shr_extn),
        .left_o   (shl_res),
        .right_o  (shr_res)
    );

    always_comb begin
        alu_res = '0;
        case (in_op)
            OpAdd:   alu_res = in_src0 + in_src1;
            OpSub:   alu_res = in_src0 - in_src1;
            OpSlt:   alu_res = {31'b0, $signed(in_src0) < $signed(in_src1)};
            OpSltu:  alu_res = {31'b0, in_src0 < in_src1};
            OpAnd:   alu_res = in_src0 & in_src1;
            OpOr:    alu_res = in_src0 | in_src1;
            OpXor:   alu_res = in_src0 ^ in_src1;
            OpSll:   alu_res = shl_res;
            OpSrl:   alu_res = shr_res;
            OpSra:   alu_res = shr_res;
            OpPass:  alu_res = in_src1;
            default: alu_res = '0;
        endcase
    end

    assign incoming  = '{result: alu_res, rd: in_rd};
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready_q;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = incoming;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && transfer) begin
                    main_d = incoming;
                end else if (accept) begin
                    skid_d  = incoming;
                    state_d = StTwo;
                end else if (transfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (transfer) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Flush discards everything; a same-cycle transfer has already been taken downstream.
        if (flush) begin
            state_d = StEmpty;
        end

        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage: ALU ops, throughput, skid backpressure,
// flush and asynchronous reset.
module tb_alu_ex_stage;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_src0;
    logic [31:0] in_src1;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    alu_ex_stage #(.OP_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src0    (in_src0),
        .in_src1    (in_src1),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_src0  = a;
        in_src1  = b;
        in_rd    = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 4'd0;
        in_src0  = '0;
        in_src1  = '0;
        in_rd    = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        vecs[0]  = '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
        vecs[1]  = '{4'd5,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0};
        vecs[2]  = '{4'd6,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0};
        vecs[3]  = '{4'd10, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_1234};
        vecs[4]  = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[5]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[6]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[7]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[8]  = '{4'd7,  32'h0000_00FF, 32'h0000_0118, 32'hFF00_0000};
        vecs[9]  = '{4'd13, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
        vecs[10] = '{4'd11, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
        vecs[11] = '{4'd9,  32'h7000_0000, 32'h0000_0004, 32'h0700_0000};

        // Reset state
        #12;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_out_rd", {27'b0, out_rd}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Arithmetic vs logical right shift
        tick();
        out_ready = 1'b1;
        drive(4'd9, 32'h8000_0000, 32'd31, 5'd4);
        tick();
        check_eq("sra_valid", {31'b0, out_valid}, 32'd1);
        check_eq("sra_result", out_result, 32'hFFFF_FFFF);
        drive(4'd8, 32'h8000_0000, 32'd31, 5'd5);
        tick();
        check_eq("srl_result", out_result, 32'h0000_0001);
        check_eq("srl_rd", {27'b0, out_rd}, 32'd5);

        // Back-to-back throughput
        drive(4'd0, 32'd7, 32'd9, 5'd1);
        check_eq("b2b_ready0", {31'b0, in_ready}, 32'd1);
        tick();
        check_eq("b2b_add", out_result, 32'd16);
        check_eq("b2b_ready1", {31'b0, in_ready}, 32'd1);
        drive(4'd1, 32'd3, 32'd5, 5'd2);
        tick();
        check_eq("b2b_sub", out_result, 32'hFFFF_FFFE);
        check_eq("b2b_ready2", {31'b0, in_ready}, 32'd1);
        drive(4'd3, 32'd3, 32'hFFFF_FFFF, 5'd3);
        tick();
        check_eq("b2b_sltu", out_result, 32'd1);
        check_eq("b2b_valid", {31'b0, out_valid}, 32'd1);

        // Op table streamed one per cycle
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
            tick();
            check_eq($sformatf("vec%0d_op%0d", i, vecs[i].op), out_result, vecs[i].exp);
        end
        idle();
        tick();
        check_eq("drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure through the skid register
        out_ready = 1'b0;
        drive(4'd0, 32'd10, 32'd0, 5'd1);
        tick();
        check_eq("bp1_valid", {31'b0, out_valid}, 32'd1);
        check_eq("bp1_ready", {31'b0, in_ready}, 32'd1);
        check_eq("bp1_rd", {27'b0, out_rd}, 32'd1);
        drive(4'd0, 32'd20, 32'd0, 5'd2);
        tick();
        check_eq("bp2_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp2_rd", {27'b0, out_rd}, 32'd1);
        drive(4'd0, 32'd30, 32'd0, 5'd3);
        tick();
        check_eq("bp3_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp3_rd_stable", {27'b0, out_rd}, 32'd1);
        check_eq("bp3_res_stable", out_result, 32'd10);
        out_ready = 1'b1;
        tick();
        check_eq("bp_out2_rd", {27'b0, out_rd}, 32'd2);
        check_eq("bp_out2_res", out_result, 32'd20);
        check_eq("bp_out2_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check_eq("bp_out3_rd", {27'b0, out_rd}, 32'd3);
        check_eq("bp_out3_res", out_result, 32'd30);
        idle();
        tick();
        check_eq("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush while both registers are full
        out_ready = 1'b0;
        drive(4'd10, 32'd0, 32'd77, 5'd7);
        tick();
        drive(4'd10, 32'd0, 32'd88, 5'd8);
        tick();
        check_eq("fl_two_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(4'd10, 32'd0, 32'd99, 5'd9);
        tick();
        check_eq("fl_valid", {31'b0, out_valid}, 32'd0);
        check_eq("fl_ready", {31'b0, in_ready}, 32'd1);
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        tick();
        check_eq("fl_after1", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("fl_after2", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(4'd0, 32'd5, 32'd6, 5'd12);
        tick();
        check_eq("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        check_eq("ar_pre_res", out_result, 32'd11);
        idle();
        #1;
        rstn = 1'b0;
        #1;
        check_eq("ar_valid", {31'b0, out_valid}, 32'd0);
        check_eq("ar_result", out_result, 32'd0);
        check_eq("ar_rd", {27'b0, out_rd}, 32'd0);
        check_eq("ar_ready", {31'b0, in_ready}, 32'd1);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        drive(4'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd21);
        tick();
        check_eq("ar_first_valid", {31'b0, out_valid}, 32'd1);
        check_eq("ar_first_res", out_result, 32'hF00F_F00F);
        check_eq("ar_first_rd", {27'b0, out_rd}, 32'd21);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 Parameter: OP_W, 4, width of the operation code.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream operation present.
REQ-005 Port: in_ready  output  1  stage accepts an operation this cycle; driven from a register only.
REQ-006 Port: in_op  input  OP_W  operation code per REQ-015.
REQ-007 Port: in_src0  input  32  first operand; shifted operand for shifts.
REQ-008 Port: in_src1  input  32  second operand; bits [4:0] are the shift amount for shifts.
REQ-009 Port: in_rd  input  5  destination register tag, passed through unchanged.
REQ-010 Port: flush  input  1  discard all held and incoming operations.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: out_result  output  32  computed result.
REQ-014 Port: out_rd  output  5  tag paired with out_result.

Function
REQ-015 Op codes: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 PASS (src1); codes 11-15 produce result 0.
REQ-016 ADD/SUB wrap modulo 2^32; no overflow flag; SLT/SLTU give 32'h1 or 32'h0.
REQ-017 SLL uses the left-shift result, SRL/SRA the right-shift result, of one Shifter instance; extn = 0 for SRL, in_src0[31] for SRA.
REQ-018 Result computed combinationally from the input and captured at acceptance; accepted op appears on out_* no earlier than the next cycle (latency 1 when unblocked).
REQ-019 Acceptance = in_valid & in_ready; transfer = out_valid & out_ready.
REQ-020 Storage: main register (drives out_*) plus one skid register; FSM states EMPTY, ONE (main full), TWO (main and skid full).
REQ-021 EMPTY: accept -> ONE.
REQ-022 ONE: accept & transfer -> ONE (main reloaded); accept & !transfer -> TWO (into skid); transfer & !accept -> EMPTY; neither -> ONE.
REQ-023 TWO: transfer -> ONE with skid moved to main; otherwise hold; no acceptance possible.
REQ-024 in_ready = 1 in EMPTY and ONE, 0 in TWO; sustained throughput one op per cycle when out_ready stays high.
REQ-025 out_valid = 1 in ONE and TWO; out_result/out_rd stable while out_valid & !out_ready.
REQ-026 Order preserved: results leave in acceptance order.
REQ-027 flush high: next state EMPTY, any simultaneous acceptance discarded, a simultaneous transfer still counts downstream; flush has priority over all other transitions.

Reset
REQ-028 rstn low asynchronously forces state EMPTY, out_valid 0, in_ready 1, out_result 0, out_rd 0, skid contents 0.
REQ-029 Reset mid-operation drops held results; first acceptance possible in the first cycle after rstn deasserts.

Structure
REQ-030 Op-code constants and the state encoding live in the shared CPU package; OP_W default equals the package op width.
REQ-031 Exactly one sub-module: the existing Shifter block, instanced once, shift amount in_src1[4:0].
REQ-032 No combinational path from out_ready to in_ready.

Verification
REQ-033 SRA src0=32'h8000_0000, src1=31, out_ready=1 -> next cycle out_valid=1, out_result=32'hFFFF_FFFF; SRL same operands -> 32'h0000_0001.
REQ-034 Back-to-back ADD 7+9, SUB 3-5, SLTU 3<32'hFFFF_FFFF, out_ready=1 -> results 16, 32'hFFFF_FFFE, 1 on consecutive cycles, in_ready constant 1.
REQ-035 out_ready=0, issue ops tagged rd=1,2,3 -> in_ready falls after 2nd accept, 3rd held upstream; raise out_ready -> rd 1,2,3 emerge in order.
REQ-036 State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and incoming ops never appear.
REQ-037 rstn pulsed low mid-stream with out_valid=1 -> out_valid=0 and out_result=0 immediately, without clock edge.
REQ-038 SLL src0=32'h0000_00FF, src1=32'h0000_0118 -> 32'hFF00_0000 (only bits [4:0] used); op 13 -> 0.
